mul_issue_sequencer: RTL
========================

Name: mul_issue_sequencer

Overview:
Sits between the instruction decoder and the execute/writeback stages. Registers each decoded 20-bit control word onto the datapath. When a word has the multiplier start bit set, the block:
- launches the multi-cycle multiplier,
- stalls the front end until the multiplier reports done,
- issues a single writeback control word that selects the multiplier result into the register file.

Parameters:
CW_W, 20, control word width; layout fixed as {start[19], rd[18:15], rt[14:11], rs[10:7], weRegFile[6], selMux03[5], weRAM[4], selMux02[3], selALU[2:1], selMux01[0]}
CNT_W, 8, width of the wait-cycle counter
TIMEOUT, 64, wait cycles before abort (used only with MUL_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cw_in  in  CW_W  decoded control word from decoder
cw_valid  in  1  cw_in holds a valid instruction this cycle
mul_done  in  1  multiplier result ready (level or pulse)
cw_out  out  CW_W  registered control word to datapath
start_mul  out  1  one-cycle multiplier launch pulse
stall  out  1  front end must hold cw_in/cw_valid
mul_wait_cnt  out  CNT_W  cycles spent in WAIT for current multiply
mul_err  out  1  one-cycle timeout pulse (tied 0 without macro)

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, cw_out=NOP=20'h00018 (weRAM=1 read, selMux02=1 ALU, all else 0)
  - start_mul=0, stall=0, mul_wait_cnt=0, mul_err=0
- States: IDLE, START, WAIT, WB. stall = (state != IDLE), Moore output.
- IDLE:
  - cw_valid=1, cw_in[19]=0: cw_out <= cw_in next edge (1-cycle latency); stay IDLE.
  - cw_valid=0: cw_out <= NOP.
  - cw_valid=1, cw_in[19]=1: capture cw_in in hold register; cw_out <= NOP; go to START.
- START (1 cycle): start_mul=1; cw_out=NOP; mul_wait_cnt cleared to 0; mul_done ignored; go to WAIT.
- WAIT:
  - cw_out=NOP.
  - mul_wait_cnt increments each cycle and saturates at all-ones.
  - mul_done=1 sampled: go to WB.
- WB (1 cycle): cw_out = held word with start=0, selMux02=0 (multiplier), weRegFile=1; other fields unchanged; go to IDLE.
- While stall=1:
  - cw_in and cw_valid are ignored; upstream holds them.
  - The first instruction sampled after WB is the held upstream word.
- mul_done outside WAIT: ignored.
- Back-to-back MULs: the second MUL is sampled in the IDLE cycle after WB and goes to START; no extra bubble beyond this sequence.
- start_mul is never asserted for more than 1 consecutive cycle.
- Reset mid-operation: immediate return to IDLE; the held word is discarded; no writeback is issued.

Optional Feature:
MUL_TIMEOUT_EN
- Defined:
  - In WAIT, if mul_wait_cnt == TIMEOUT-1 and mul_done=0, pulse mul_err=1 for 1 cycle and go to IDLE. cw_out=NOP, no writeback.
  - mul_done in that same cycle takes priority: go to WB, no error.
- Undefined: WAIT lasts until mul_done; mul_err tied 0; TIMEOUT unused.

Test Plan:
- Reset: assert rst mid-cycle -> immediately cw_out=20'h00018, stall=0, start_mul=0, mul_err=0.
- ADD pass-through: cw_in=20'h190D8 (rd3, rt2, rs1), cw_valid=1 -> next cycle cw_out=20'h190D8, stall=0, start_mul=0.
- MUL sequence: cw_in=20'h AA350 (rd5, rt4, rs6) at cycle 0; mul_done=1 at cycle 6 ->
  - cycle 1: start_mul=1.
  - cycles 1–7: stall=1.
  - cycle 7: cw_out=20'h2A350.
  - cycle 8: stall=0.
  - mul_wait_cnt=5 at the WB cycle.
- Spurious done: mul_done=1 during START and while IDLE -> no WB; WAIT entered normally; start_mul pulses only once.
- Reset mid-WAIT: rst at cycle 3 of the MUL sequence -> IDLE, no 20'h2A350 ever appears on cw_out.
- With MUL_TIMEOUT_EN, TIMEOUT=8, mul_done held 0 -> mul_err pulses once after 8 WAIT cycles; stall=0 the next cycle; cw_out stays NOP.

Source files
------------

// File: rtl/mul_issue_sequencer_if.sv
// Handshake bundle between the decoder/multiplier side and mul_issue_sequencer.
// master = environment (decoder + multiplier), slave = the sequencer itself.
interface mul_issue_sequencer_if #(
  parameter int CW_W  = 20,
  parameter int CNT_W = 8
);
  logic [CW_W-1:0]  cw_in;
  logic             cw_valid;
  logic             mul_done;
  logic [CW_W-1:0]  cw_out;
  logic             start_mul;
  logic             stall;
  logic [CNT_W-1:0] mul_wait_cnt;
  logic             mul_err;

  modport master (
    output cw_in, cw_valid, mul_done,
    input  cw_out, start_mul, stall, mul_wait_cnt, mul_err
  );

  modport slave (
    input  cw_in, cw_valid, mul_done,
    output cw_out, start_mul, stall, mul_wait_cnt, mul_err
  );
endinterface

// File: rtl/mul_issue_sequencer.sv
// Registers decoded control words onto the datapath and sequences multi-cycle multiplies
// (launch, stall, writeback). Optional wait timeout enabled by defining MUL_TIMEOUT_EN.
module mul_issue_sequencer #(
  parameter int CW_W    = 20,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  mul_issue_sequencer_if.slave bus
);

  localparam int START_B = 19;
  localparam int WE_RF_B = 6;
  localparam int SEL02_B = 3;
  localparam logic [CW_W-1:0] NOP = CW_W'(20'h00018);

  if (CW_W != 20) begin : g_bad_cw_w
    $error("mul_issue_sequencer: control word layout is fixed at 20 bits");
  end
  if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W)) begin : g_bad_timeout
    $error("mul_issue_sequencer: TIMEOUT must fit the wait counter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WB
  } state_e;

  state_e           state_q, state_d;
  logic [CW_W-1:0]  cw_out_q, cw_out_d;
  logic [CW_W-1:0]  hold_q, hold_d;
  logic             start_mul_q, start_mul_d;
  logic             stall_q, stall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mul_err_q, mul_err_d;

`ifdef MUL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Writeback word: clear start, route the multiplier through mux02, enable the regfile write.
  function automatic logic [CW_W-1:0] wb_word(input logic [CW_W-1:0] w);
    logic [CW_W-1:0] r;
    r          = w;
    r[START_B] = 1'b0;
    r[SEL02_B] = 1'b0;
    r[WE_RF_B] = 1'b1;
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cw_out_d    = NOP;
    hold_d      = hold_q;
    start_mul_d = 1'b0;
    cnt_d       = cnt_q;
    mul_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cw_valid) begin
          if (bus.cw_in[START_B]) begin
            state_d     = S_START;
            hold_d      = bus.cw_in;
            start_mul_d = 1'b1;
            cnt_d       = '0;
          end else begin
            cw_out_d = bus.cw_in;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = sat_inc(cnt_q);
        if (bus.mul_done) begin
          state_d  = S_WB;
          cw_out_d = wb_word(hold_q);
        end
`ifdef MUL_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = S_IDLE;
          mul_err_d = 1'b1;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    stall_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cw_out_q    <= NOP;
      start_mul_q <= 1'b0;
      stall_q     <= 1'b0;
      cnt_q       <= '0;
      mul_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cw_out_q    <= cw_out_d;
      start_mul_q <= start_mul_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
      mul_err_q   <= mul_err_d;
    end
  end

  // The held word is only ever read in WAIT, which is always entered through a capture.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign bus.cw_out       = cw_out_q;
  assign bus.start_mul    = start_mul_q;
  assign bus.stall        = stall_q;
  assign bus.mul_wait_cnt = cnt_q;
  assign bus.mul_err      = mul_err_q;

endmodule
